// File: rtl/sync_framer.sv
// Attached-sync-marker framer: prepends SYNC_MARKER to each codeword and pads
// short codewords to CODEWORD_LEN bytes, with a single registered output stage.
module sync_framer #(
    parameter logic [31:0] SYNC_MARKER  = 32'h1ACFFC1D,
    parameter int unsigned CODEWORD_LEN = 255,
    parameter logic [7:0]  PAD_BYTE     = 8'h00
) (
    input  logic       core_clk,
    input  logic       rst_n,
    input  logic [7:0] s_axis_input_tdata,
    input  logic       s_axis_input_tvalid,
    input  logic       s_axis_input_tlast,
    output logic       s_axis_input_tready,
    output logic [7:0] m_axis_output_tdata,
    output logic       m_axis_output_tvalid,
    output logic       m_axis_output_tlast,
    input  logic       m_axis_output_tready,
    output logic [15:0] frame_cnt,
    output logic       err_len
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 16;
    localparam logic [BYTE_W-1:0] LEN_B = BYTE_W'(CODEWORD_LEN);

    typedef enum logic [1:0] {IDLE, SYNC, DATA, PAD} state_e;

    state_e             state_q, state_d;
    logic [BYTE_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [1:0]         mk_idx_q, mk_idx_d;
    logic [BYTE_W-1:0]  tdata_q, tdata_d;
    logic               tvalid_q, tvalid_d;
    logic               tlast_q, tlast_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic               err_len_q, err_len_d;
    logic [1:0]         rst_sync_q;

    logic               load;
    logic               run_ok;
    logic [BYTE_W-1:0]  cnt_next;
    logic [BYTE_W-1:0]  marker_byte;

    assign load     = !tvalid_q || m_axis_output_tready;
    assign run_ok   = rst_sync_q[1];
    assign cnt_next = byte_cnt_q + BYTE_W'(1);

    assign s_axis_input_tready  = (state_q == DATA) && load;
    assign m_axis_output_tdata  = tdata_q;
    assign m_axis_output_tvalid = tvalid_q;
    assign m_axis_output_tlast  = tlast_q;
    assign frame_cnt            = frame_cnt_q;
    assign err_len              = err_len_q;

    // Marker is sent most significant byte first.
    always_comb begin
        case (mk_idx_q)
            2'd0:    marker_byte = SYNC_MARKER[31:24];
            2'd1:    marker_byte = SYNC_MARKER[23:16];
            2'd2:    marker_byte = SYNC_MARKER[15:8];
            default: marker_byte = SYNC_MARKER[7:0];
        endcase
    end

    // Release of reset is held off by two flops so the FSM starts on a clean edge.
    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            byte_cnt_q  <= '0;
            mk_idx_q    <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            frame_cnt_q <= '0;
            err_len_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            mk_idx_q    <= mk_idx_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            frame_cnt_q <= frame_cnt_d;
            err_len_q   <= err_len_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        mk_idx_d    = mk_idx_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        frame_cnt_d = frame_cnt_q;
        err_len_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (load) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    if (s_axis_input_tvalid && run_ok) begin
                        state_d  = SYNC;
                        mk_idx_d = '0;
                    end
                end
            end
            SYNC: begin
                if (load) begin
                    tdata_d  = marker_byte;
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    mk_idx_d = mk_idx_q + 2'd1;
                    if (mk_idx_q == 2'd3) begin
                        state_d    = DATA;
                        byte_cnt_d = '0;
                    end
                end
            end
            DATA: begin
                if (load) begin
                    if (s_axis_input_tvalid) begin
                        tdata_d  = s_axis_input_tdata;
                        tvalid_d = 1'b1;
                        if (cnt_next == LEN_B) begin
                            // Full length reached; a missing tlast means the codeword ran long.
                            tlast_d     = 1'b1;
                            frame_cnt_d = frame_cnt_q + CNT_W'(1);
                            err_len_d   = !s_axis_input_tlast;
                            byte_cnt_d  = '0;
                            state_d     = IDLE;
                        end else begin
                            tlast_d    = 1'b0;
                            byte_cnt_d = cnt_next;
                            if (s_axis_input_tlast) begin
                                err_len_d = 1'b1;
                                state_d   = PAD;
                            end
                        end
                    end else begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                    end
                end
            end
            PAD: begin
                if (load) begin
                    tdata_d  = PAD_BYTE;
                    tvalid_d = 1'b1;
                    if (cnt_next == LEN_B) begin
                        tlast_d     = 1'b1;
                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
                        byte_cnt_d  = '0;
                        state_d     = IDLE;
                    end else begin
                        tlast_d    = 1'b0;
                        byte_cnt_d = cnt_next;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sync_framer.sv
// Bench for sync_framer: randomized codeword streams scored against a
// frame-level model of marker insertion, padding and length errors.
module tb_sync_framer;

    localparam int LEN = 255;

    logic        core_clk;
    logic        rst_n;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;
    logic [15:0] frame_cnt;
    logic        err_len;

    sync_framer dut (
        .core_clk             (core_clk),
        .rst_n                (rst_n),
        .s_axis_input_tdata   (s_tdata),
        .s_axis_input_tvalid  (s_tvalid),
        .s_axis_input_tlast   (s_tlast),
        .s_axis_input_tready  (s_tready),
        .m_axis_output_tdata  (m_tdata),
        .m_axis_output_tvalid (m_tvalid),
        .m_axis_output_tlast  (m_tlast),
        .m_axis_output_tready (m_tready),
        .frame_cnt            (frame_cnt),
        .err_len              (err_len)
    );

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] in_d[$];
    bit         in_l[$];
    logic [7:0] out_d[$];
    bit         out_l[$];
    int         last_cyc[$];

    int   cyc = 0;
    int   err_pulses = 0;
    int   err_wide = 0;
    int   stab_viol = 0;
    bit   prev_stall = 0;
    bit   prev_err = 0;
    logic [7:0] prev_d;
    logic prev_l;

    // Output monitor: records accepted beats, err_len pulses and stall stability.
    always @(negedge core_clk) begin
        cyc++;
        if (!rst_n) begin
            prev_stall = 0;
            prev_err   = 0;
        end else begin
            if (prev_stall && (m_tvalid !== 1'b1 || m_tdata !== prev_d || m_tlast !== prev_l))
                stab_viol++;
            prev_stall = (m_tvalid === 1'b1) && (m_tready === 1'b0);
            prev_d = m_tdata;
            prev_l = m_tlast;
            if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
                out_d.push_back(m_tdata);
                out_l.push_back(m_tlast);
                if (m_tlast === 1'b1) last_cyc.push_back(cyc);
            end
            if (err_len === 1'b1) begin
                if (prev_err) err_wide++;
                else err_pulses++;
            end
            prev_err = (err_len === 1'b1);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " m_tvalid"}, 32'(m_tvalid), 0);
        check({tag, " m_tdata"}, 32'(m_tdata), 0);
        check({tag, " m_tlast"}, 32'(m_tlast), 0);
        check({tag, " s_tready"}, 32'(s_tready), 0);
        check({tag, " frame_cnt"}, 32'(frame_cnt), 0);
        check({tag, " err_len"}, 32'(err_len), 0);
    endtask

    // Drives in_d/in_l through the DUT and scores output against the frame model.
    task automatic run_test(input string tag, input bit rnd_ready, input int budget);
        logic [7:0] exp_d[$];
        bit         exp_l[$];
        int exp_frames = 0;
        int exp_errs = 0;
        int exp_lasts = 0;
        int i = 0;
        int n = in_d.size();
        int idx = 0;
        bit acc = 0;
        int used = 0;
        int mism = 0;
        int lasts = 0;
        int first_bad = -1;
        int err_base = err_pulses;
        logic [15:0] fc_base = frame_cnt;
        logic [31:0] mk = 32'h1ACFFC1D;

        while (i < n) begin
            int cnt = 0;
            bit done = 0;
            for (int k = 3; k >= 0; k--) begin
                exp_d.push_back(mk[k*8 +: 8]);
                exp_l.push_back(0);
            end
            while (!done && i < n) begin
                logic [7:0] b = in_d[i];
                bit l = in_l[i];
                i++;
                cnt++;
                if (cnt == LEN) begin
                    exp_d.push_back(b); exp_l.push_back(1);
                    exp_frames++;
                    if (!l) exp_errs++;
                    done = 1;
                end else if (l) begin
                    exp_d.push_back(b); exp_l.push_back(0);
                    exp_errs++;
                    for (int p = cnt + 1; p <= LEN; p++) begin
                        exp_d.push_back(8'h00);
                        exp_l.push_back(p == LEN);
                    end
                    exp_frames++;
                    done = 1;
                end else begin
                    exp_d.push_back(b); exp_l.push_back(0);
                end
            end
        end
        foreach (exp_l[k]) if (exp_l[k]) exp_lasts++;

        out_d.delete();
        out_l.delete();
        last_cyc.delete();

        while (used < budget) begin
            @(posedge core_clk);
            #1;
            if (acc) idx++;
            if (idx < n) begin
                s_tvalid = 1'b1;
                s_tdata  = in_d[idx];
                s_tlast  = in_l[idx];
            end else begin
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
            end
            m_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge core_clk);
            acc = s_tvalid && s_tready;
            used++;
            if (idx >= n && out_d.size() >= exp_d.size()) break;
        end
        check({tag, " timeout"}, 32'(used < budget), 1);
        m_tready = 1'b1;
        repeat (4) @(negedge core_clk);

        for (int k = 0; k < out_d.size() && k < exp_d.size(); k++) begin
            if (out_d[k] !== exp_d[k] || out_l[k] !== exp_l[k]) begin
                mism++;
                if (first_bad < 0) first_bad = k;
            end
        end
        foreach (out_l[k]) if (out_l[k]) lasts++;
        check({tag, " beat count"}, 32'(out_d.size()), 32'(exp_d.size()));
        check({tag, " beat mismatches"}, 32'(mism), 0);
        if (first_bad >= 0)
            check({tag, " first bad beat data"}, 32'(out_d[first_bad]), 32'(exp_d[first_bad]));
        check({tag, " tlast count"}, 32'(lasts), 32'(exp_lasts));
        check({tag, " frame_cnt delta"}, 32'(16'(frame_cnt - fc_base)), 32'(exp_frames));
        check({tag, " err_len pulses"}, 32'(err_pulses - err_base), 32'(exp_errs));
        check({tag, " err_len width"}, 32'(err_wide), 0);
        check({tag, " stall stability"}, 32'(stab_viol), 0);
    endtask

    task automatic load_codeword(input int nbytes, input bit ramp, input bit with_last);
        in_d.delete();
        in_l.delete();
        for (int k = 0; k < nbytes; k++) begin
            in_d.push_back(ramp ? 8'(k) : 8'($urandom_range(0, 255)));
            in_l.push_back(with_last && (k == nbytes - 1));
        end
    endtask

    initial begin
        int wait_cnt;
        rst_n    = 1'b0;
        s_tdata  = 8'h00;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        repeat (3) @(negedge core_clk);
        check_reset_outputs("reset");

        @(posedge core_clk); #1 rst_n = 1'b1;
        repeat (3) @(negedge core_clk);

        load_codeword(255, 1, 1);
        run_test("ramp255", 0, 2000);
        check("ramp255 frame_cnt abs", 32'(frame_cnt), 1);

        run_test("ramp255_stall", 1, 6000);

        load_codeword(10, 0, 1);
        run_test("short10", 1, 6000);

        in_d.delete();
        in_l.delete();
        for (int f = 0; f < 3; f++)
            for (int k = 0; k < 255; k++) begin
                in_d.push_back(8'($urandom_range(0, 255)));
                in_l.push_back(k == 254);
            end
        run_test("b2b3", 0, 3000);
        check("b2b3 frames seen", 32'(last_cyc.size()), 3);
        if (last_cyc.size() == 3) begin
            check("b2b3 spacing 1", 32'(last_cyc[1] - last_cyc[0]), 260);
            check("b2b3 spacing 2", 32'(last_cyc[2] - last_cyc[1]), 260);
        end

        load_codeword(300, 0, 0);
        run_test("long300", 1, 8000);

        // Clear the partial frame left by the long codeword, then reset mid-marker.
        @(posedge core_clk); #1 rst_n = 1'b0;
        repeat (2) @(negedge core_clk);
        @(posedge core_clk); #1 rst_n = 1'b1;
        repeat (3) @(negedge core_clk);
        out_d.delete();
        out_l.delete();
        @(posedge core_clk); #1;
        s_tvalid = 1'b1;
        s_tdata  = 8'h5A;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        wait_cnt = 0;
        while (out_d.size() < 2 && wait_cnt < 50) begin
            @(negedge core_clk);
            wait_cnt++;
        end
        check("midreset marker seen", 32'(wait_cnt < 50), 1);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("midreset async");
        repeat (2) @(negedge core_clk);
        check_reset_outputs("midreset held");
        @(posedge core_clk); #1 rst_n = 1'b1;
        @(negedge core_clk);
        check("midreset sync hold 1", 32'(m_tvalid), 0);
        @(negedge core_clk);
        check("midreset sync hold 2", 32'(m_tvalid), 0);
        load_codeword(255, 0, 1);
        run_test("after_reset", 0, 2000);
        check("after_reset frame_cnt abs", 32'(frame_cnt), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
